hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and sequencing controller for the decode/execute boundary of the 5-stage core. It decides every cycle whether the fetch and F/D stages advance, hold or flush. It also decides whether the D/EX register loads, receives a bubble via `stall_D`, or holds. It sequences the multi-cycle multiplier and freezes the pipe on data-memory wait. Saturating performance counters track stall cycles and flush events.

## Interface
- `XLEN`, 32: datapath width; used only for the counter default.
- `MUL_LAT`, 4: total EX-occupancy cycles of a multiply; legal range ≥2.
- `CNT_W`, 32: width of the performance counters.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `D_rs1`, `D_rs2`  in  5 each  source registers of the instruction in D.
- `D_use_rs1`, `D_use_rs2`  in  1 each  the D instruction actually reads that source.
- `EX_rd`  in  5  destination register of the instruction in EX.
- `EX_ld`, `EX_we`, `EX_mul`  in  1 each  the EX instruction is a load / writes back / is a multiply.
- `EX_taken`  in  1  branch resolved taken in EX. Never asserted together with `EX_mul`.
- `mem_busy`  in  1  the MEM stage cannot complete this cycle (cache miss).
- `stall_F`  out  1  PC and F/D register hold.
- `flush_F`  out  1  F/D register loads a bubble.
- `stall_D`  out  1  D/EX register loads a bubble.
- `hold_EX`  out  1  D/EX register and EX stage retain contents; EX/MEM receives a bubble.
- `hold_M`  out  1  EX/MEM and MEM/WB hold.
- `mul_start`  out  1  one-cycle pulse; the multiplier latches its operands.
- `mul_done`  out  1  one-cycle pulse; the multiplier result is valid and EX may advance.
- `stall_cycles`  out  `CNT_W`  saturating count of cycles with `stall_F`=1.
- `flush_count`  out  `CNT_W`  saturating count of cycles with `flush_F`=1.

## Operation
- FSM states: `IDLE`, `MUL_BUSY`. A down-counter `mcnt` (width clog2(`MUL_LAT`)) runs in `MUL_BUSY`.
- Load-use hazard (`lu`) is true when all of the following hold:
  - `EX_ld` & `EX_we` & `EX_rd`≠0, and
  - (`D_use_rs1` & `D_rs1`==`EX_rd`) or (`D_use_rs2` & `D_rs2`==`EX_rd`).
- Outputs are combinational from the state and inputs. Conditions are evaluated in priority order; the first match applies, and outputs not listed are 0:
  1. `rst`: all outputs 0. Next state `IDLE`, `mcnt`=0, counters cleared.
  2. `mem_busy`: `stall_F`, `hold_EX`, `hold_M`. A pending `EX_taken` or `lu` is deferred, because those instructions stay in place.
  3. `IDLE` & `EX_taken`: `flush_F`, `stall_D`. `stall_F`=0 so the PC redirect loads.
  4. `IDLE` & `EX_mul`: `mul_start`, `stall_F`, `hold_EX`. Next state `MUL_BUSY`, `mcnt`=`MUL_LAT`-1.
  5. `MUL_BUSY` & `mcnt`>1: `stall_F`, `hold_EX`; `mcnt` decrements.
  6. `MUL_BUSY` & `mcnt`==1: `mul_done`. EX advances with the result; next state `IDLE`.
  7. `IDLE` & `lu`: `stall_F`, `stall_D`. This inserts exactly one bubble per matching cycle.
- `stall_D` and `hold_EX` are never asserted together; hold wins by priority.
- While `mem_busy`=1 in `MUL_BUSY`:
  - `mcnt` keeps decrementing while >1, since the multiplier runs independently.
  - At `mcnt`==1 the block waits: no `mul_done`, and the state is held until `mem_busy` falls.
- Counters increment by 1 per qualifying cycle and saturate at 2^`CNT_W`-1 (no wrap).

## Timing
- Zero-cycle latency: all control outputs react in the same cycle as their inputs. State, `mcnt` and the counters update at the posedge.
- A multiply occupies EX for exactly `MUL_LAT` cycles when `mem_busy`=0:
  - 1 start cycle plus (`MUL_LAT`-2) busy cycles, all with `hold_EX`=1;
  - then 1 done cycle with `hold_EX`=0.
- `hold_EX` and `stall_F` are therefore high for `MUL_LAT`-1 consecutive cycles.
- `mul_start` and `mul_done` are each exactly 1 cycle wide, are never high together, and occur once per multiply.
- A load-use stall lasts 1 cycle: the next cycle EX holds a bubble, so `EX_ld`=0.
- Reset mid-multiply aborts it: the next cycle is `IDLE` with no `mul_done` pulse.
- Counters read 0 in the first cycle after `rst` deasserts.

## Test plan
- Load-use: `EX_ld`=`EX_we`=1, `EX_rd`=5, `D_rs2`=5, `D_use_rs2`=1.
  -> `stall_F`=`stall_D`=1 for one cycle; `stall_cycles` goes 0→1.
- Same as above but with `EX_rd`=0 or `D_use_rs2`=0.
  -> no stall; all outputs 0.
- Multiply, `MUL_LAT`=4, `EX_mul`=1:
  - `mul_start` in cycle 0;
  - `hold_EX`=`stall_F`=1 in cycles 0–2;
  - `mul_done` in cycle 3 with `hold_EX`=0;
  - `stall_cycles`=3.
- Multiply with `mem_busy`=1 in cycles 2–5.
  -> `mul_done` delayed to cycle 6; `hold_M`=1 in cycles 2–5; `mul_start` pulses exactly once.
- `EX_taken`=1 together with `lu`=1.
  -> `flush_F`=`stall_D`=1, `stall_F`=0; `flush_count` increments.
- Same, but with `mem_busy`=1 concurrently.
  -> freeze only: no flush until `mem_busy` drops.
- Counter saturation (`CNT_W`=4) under 20 consecutive load-use stalls.
  -> `stall_cycles` holds at 15.
- Reset mid-multiply: `rst` pulsed in cycle 1 of a multiply.
  -> next cycle `IDLE`, no `mul_done`, counters 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Decode/execute hazard controller: load-use stalls, branch flushes, multi-cycle multiply
// sequencing, memory-wait freeze, and saturating stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       D_rs1,
  input  logic [4:0]       D_rs2,
  input  logic             D_use_rs1,
  input  logic             D_use_rs2,
  input  logic [4:0]       EX_rd,
  input  logic             EX_ld,
  input  logic             EX_we,
  input  logic             EX_mul,
  input  logic             EX_taken,
  input  logic             mem_busy,
  output logic             stall_F,
  output logic             flush_F,
  output logic             stall_D,
  output logic             hold_EX,
  output logic             hold_M,
  output logic             mul_start,
  output logic             mul_done,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned      McntW    = $clog2(MUL_LAT);
  localparam logic [McntW-1:0] McntInit = McntW'(MUL_LAT - 1);
  localparam logic [McntW-1:0] McntOne  = McntW'(1);

  typedef enum logic [0:0] {StIdle, StMulBusy} state_e;

  state_e             state_q, state_d;
  logic [McntW-1:0]   mcnt_q, mcnt_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]   flush_count_q, flush_count_d;
  logic               lu;

  assign lu = EX_ld && EX_we && (EX_rd != 5'd0) &&
              ((D_use_rs1 && (D_rs1 == EX_rd)) || (D_use_rs2 && (D_rs2 == EX_rd)));

  always_ff @(posedge clk) begin
    state_q        <= state_d;
    mcnt_q         <= mcnt_d;
    stall_cycles_q <= stall_cycles_d;
    flush_count_q  <= flush_count_d;
  end

  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    if (rst) begin
      state_d = StIdle;
      mcnt_d  = '0;
    end else if (state_q == StMulBusy) begin
      // The multiplier keeps counting through a memory wait; only completion waits for it.
      if (mcnt_q > McntOne) begin
        mcnt_d = mcnt_q - McntOne;
      end else if (!mem_busy) begin
        state_d = StIdle;
        mcnt_d  = '0;
      end
    end else if (!mem_busy && !EX_taken && EX_mul) begin
      state_d = StMulBusy;
      mcnt_d  = McntInit;
    end
  end

  always_comb begin
    stall_F   = 1'b0;
    flush_F   = 1'b0;
    stall_D   = 1'b0;
    hold_EX   = 1'b0;
    hold_M    = 1'b0;
    mul_start = 1'b0;
    mul_done  = 1'b0;
    if (rst) begin
      stall_F = 1'b0;
    end else if (mem_busy) begin
      stall_F = 1'b1;
      hold_EX = 1'b1;
      hold_M  = 1'b1;
    end else if (state_q == StIdle && EX_taken) begin
      flush_F = 1'b1;
      stall_D = 1'b1;
    end else if (state_q == StIdle && EX_mul) begin
      mul_start = 1'b1;
      stall_F   = 1'b1;
      hold_EX   = 1'b1;
    end else if (state_q == StMulBusy && mcnt_q > McntOne) begin
      stall_F = 1'b1;
      hold_EX = 1'b1;
    end else if (state_q == StMulBusy) begin
      mul_done = 1'b1;
    end else if (lu) begin
      stall_F = 1'b1;
      stall_D = 1'b1;
    end
  end

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (rst) begin
      stall_cycles_d = '0;
      flush_count_d  = '0;
    end else begin
      if (stall_F && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
      if (flush_F && (flush_count_q != '1))  flush_count_d  = flush_count_q + 1'b1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then random traffic, all checked against a
// cycle-level model that tracks multiply age and counter totals directly.
module tb_hazard_ctrl;
  localparam int unsigned MulLat = 4;
  localparam int unsigned CntW   = 4;
  localparam int          CntMax = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst, mem_busy, ex_ld, ex_we, ex_mul, ex_taken, d_use_rs1, d_use_rs2;
  logic [4:0]      d_rs1, d_rs2, ex_rd;
  logic            stall_f, flush_f, stall_d, hold_ex, hold_m, mul_start, mul_done;
  logic [CntW-1:0] stall_cycles, flush_count;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference state: multiply in flight and cycles elapsed since its start cycle.
  bit m_busy = 1'b0;
  int m_age  = 0;
  int m_stall = 0;
  int m_flush = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.XLEN(32), .MUL_LAT(MulLat), .CNT_W(CntW)) u_dut (
    .clk(clk), .rst(rst),
    .D_rs1(d_rs1), .D_rs2(d_rs2), .D_use_rs1(d_use_rs1), .D_use_rs2(d_use_rs2),
    .EX_rd(ex_rd), .EX_ld(ex_ld), .EX_we(ex_we), .EX_mul(ex_mul), .EX_taken(ex_taken),
    .mem_busy(mem_busy),
    .stall_F(stall_f), .flush_F(flush_f), .stall_D(stall_d), .hold_EX(hold_ex),
    .hold_M(hold_m), .mul_start(mul_start), .mul_done(mul_done),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One cycle: drive inputs after negedge, check outputs and counters, advance the model.
  task automatic step(input bit r, input bit mb, input bit ld, input bit we, input bit mul,
                      input bit tk, input bit u1, input bit u2,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    bit lu;
    logic [6:0] exp;
    @(negedge clk);
    rst = r; mem_busy = mb; ex_ld = ld; ex_we = we; ex_mul = mul; ex_taken = tk;
    d_use_rs1 = u1; d_use_rs2 = u2; ex_rd = rd; d_rs1 = rs1; d_rs2 = rs2;
    #1;
    lu  = ld && we && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    // {stall_F, flush_F, stall_D, hold_EX, hold_M, mul_start, mul_done}
    exp = 7'b0;
    if (r) begin
      exp = 7'b0;
    end else if (mb) begin
      exp = 7'b1001100;
      if (m_busy) m_age++;
    end else if (!m_busy && tk) begin
      exp = 7'b0110000;
    end else if (!m_busy && mul) begin
      exp = 7'b1001010;
      m_busy = 1'b1;
      m_age  = 1;
    end else if (m_busy && m_age < MulLat - 1) begin
      exp = 7'b1001000;
      m_age++;
    end else if (m_busy) begin
      exp = 7'b0000001;
      m_busy = 1'b0;
    end else if (lu) begin
      exp = 7'b1010000;
    end
    check_eq("ctrl", {25'b0, stall_f, flush_f, stall_d, hold_ex, hold_m, mul_start, mul_done},
             {25'b0, exp});
    check_eq("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    check_eq("flush_count", 32'(flush_count), 32'(m_flush));
    if (r) begin
      m_busy = 1'b0; m_age = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (exp[6] && m_stall < CntMax) m_stall++;
      if (exp[5] && m_flush < CntMax) m_flush++;
    end
  endtask

  task automatic idle(input bit mb);
    step(1'b0, mb, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic mul_cyc(input bit r, input bit mb, input bit mul);
    step(r, mb, 1'b0, 1'b0, mul, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic lu_cyc(input bit mb, input bit tk, input logic [4:0] rd, input bit u2);
    step(1'b0, mb, 1'b1, 1'b1, 1'b0, tk, 1'b0, u2, rd, 5'd1, 5'd5);
  endtask

  initial begin
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    idle(1'b0);
    // Load-use, then the non-hazard variants.
    lu_cyc(1'b0, 1'b0, 5'd5, 1'b1);
    idle(1'b0);
    lu_cyc(1'b0, 1'b0, 5'd0, 1'b1);
    lu_cyc(1'b0, 1'b0, 5'd5, 1'b0);
    // Plain multiply, then multiply with memory wait in cycles 2..5.
    mul_cyc(1'b0, 1'b0, 1'b1);
    for (int i = 1; i < 5; i++) mul_cyc(1'b0, 1'b0, 1'b0);
    mul_cyc(1'b0, 1'b0, 1'b1);
    for (int i = 1; i < 8; i++) mul_cyc(1'b0, (i >= 2 && i <= 5), 1'b0);
    // Branch taken with a load-use, alone and under a memory wait.
    lu_cyc(1'b0, 1'b1, 5'd5, 1'b1);
    lu_cyc(1'b1, 1'b1, 5'd5, 1'b1);
    lu_cyc(1'b1, 1'b1, 5'd5, 1'b1);
    lu_cyc(1'b0, 1'b1, 5'd5, 1'b1);
    // Saturation under 20 back-to-back load-use stalls.
    for (int i = 0; i < 20; i++) lu_cyc(1'b0, 1'b0, 5'd5, 1'b1);
    @(negedge clk);
    check_eq("stall_sat", 32'(stall_cycles), 32'(CntMax));
    // Reset in cycle 1 of a multiply.
    mul_cyc(1'b0, 1'b0, 1'b1);
    mul_cyc(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) mul_cyc(1'b0, 1'b0, 1'b0);
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      bit mul, tk;
      int sel;
      sel = int'($urandom_range(0, 7));
      mul = (sel == 0);
      tk  = (sel == 1);
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) == 0), 1'($urandom),
           1'($urandom), mul, tk, 1'($urandom), 1'($urandom),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
